d_cache_nway_wb: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache, one word per line.

---
 rtl/d_cache_nway_wb.sv | 266 ++++++++++++++++++++++++++
 tb/tb_d_cache_nway_wb.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_nway_wb.sv
// d_cache_nway_wb
// N-way set-associative, write-back, write-allocate data cache with one word per line.
// The CPU side and the bus side both use the sram-like req/addr_ok/data_ok handshake.
// Replacement fills the lowest invalid way first. Once every way of a set is valid,
// it uses that set's round-robin pointer. Addresses in kseg1 can bypass the cache.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a CPU request; addr_ok follows cpu_data_req
// S_LOOKUP  | tag compare on the latched request; a hit completes here
// S_WB_REQ  | write-back request for the dirty victim, held until bus addr_ok
// S_WB_WAIT | waiting for the write-back bus data_ok
// S_RF_REQ  | refill read request, held until bus addr_ok
// S_RF_WAIT | waiting for refill data; installs the victim way on bus data_ok
// S_UC_REQ  | uncached request forwarded to the bus, held until bus addr_ok
// S_UC_WAIT | waiting for the uncached response, which goes straight to the CPU

module d_cache_nway_wb #(
  parameter int WAYS        = 2,
  parameter int INDEX_WIDTH = 6,
  parameter bit UNCACHED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int SETS  = 2 ** INDEX_WIDTH;
  localparam int TAG_W = 32 - INDEX_WIDTH - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_RF_REQ, S_RF_WAIT, S_UC_REQ, S_UC_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  // line storage
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [TAG_W-1:0] r_tag   [WAYS][SETS];
  logic [31:0]      r_data  [WAYS][SETS];
  logic [WAY_W-1:0] r_rr    [SETS];

  // latched CPU request and chosen victim
  logic             r_wr;
  logic [1:0]       r_size;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [WAY_W-1:0] r_victim;

  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_accept;
  logic                   w_uncached;
  logic                   w_hit;
  logic [WAY_W-1:0]       w_hit_way;
  logic [31:0]            w_hit_data;
  logic                   w_any_inv;
  logic [WAY_W-1:0]       w_inv_way;
  logic [WAY_W-1:0]       w_victim;
  logic                   w_victim_dirty;
  logic [WAY_W-1:0]       w_rr_next;
  logic [3:0]             w_mask;
  logic [31:0]            w_merged;
  logic                   w_refill_done;
  logic [TAG_W-1:0]       w_vic_tag;
  logic [31:0]            w_vic_data;

  assign w_index    = r_addr[INDEX_WIDTH+1:2];
  assign w_tag      = r_addr[31:INDEX_WIDTH+2];
  assign w_accept   = rst & (r_state == S_IDLE) & cpu_data_req;
  assign w_uncached = UNCACHED_EN & (cpu_data_addr[31:29] == 3'b101);
  assign w_vic_tag  = r_tag[r_victim][w_index];
  assign w_vic_data = r_data[r_victim][w_index];
  assign w_hit_data = r_data[w_hit_way][w_index];

  // A refill completes either in RF_WAIT, or in RF_REQ when the bus accepts and answers in the same cycle.
  assign w_refill_done = rst & cache_data_data_ok &
                         ((r_state == S_RF_WAIT) | ((r_state == S_RF_REQ) & cache_data_addr_ok));

  // Byte-lane mask for the latched request; misaligned sizes are not guarded.
  function automatic logic [3:0] f_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    f_mask = 4'b0001 << off;
      2'd1:    f_mask = 4'b0011 << off;
      default: f_mask = 4'b1111;
    endcase
  endfunction

  assign w_mask = f_mask(r_size, r_addr[1:0]);

  // Merge the write data into the hit line, byte by byte
  always_comb begin
    w_merged = w_hit_data;
    for (int b = 0; b < 4; b++) begin
      if (w_mask[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  // Tag compare and victim choice for the latched index
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_any_inv = 1'b0;
    w_inv_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[w_index][i] && (r_tag[i][w_index] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!r_valid[w_index][i]) begin
        w_any_inv = 1'b1;
        w_inv_way = WAY_W'(i);
      end
    end
    w_victim       = w_any_inv ? w_inv_way : r_rr[w_index];
    w_victim_dirty = r_valid[w_index][w_victim] & r_dirty[w_index][w_victim];
    if (WAYS == 1) w_rr_next = '0;
    else           w_rr_next = (r_rr[w_index] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_index] + 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; a same-cycle addr_ok+data_ok skips the WAIT state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (cpu_data_req) w_next = w_uncached ? S_UC_REQ : S_LOOKUP;
      S_LOOKUP:  if (w_hit)                w_next = S_IDLE;
                 else if (w_victim_dirty)  w_next = S_WB_REQ;
                 else                      w_next = S_RF_REQ;
      S_WB_REQ:  if (cache_data_addr_ok)   w_next = cache_data_data_ok ? S_RF_REQ : S_WB_WAIT;
      S_WB_WAIT: if (cache_data_data_ok)   w_next = S_RF_REQ;
      S_RF_REQ:  if (cache_data_addr_ok)   w_next = cache_data_data_ok ? S_LOOKUP : S_RF_WAIT;
      S_RF_WAIT: if (cache_data_data_ok)   w_next = S_LOOKUP;
      S_UC_REQ:  if (cache_data_addr_ok)   w_next = cache_data_data_ok ? S_IDLE : S_UC_WAIT;
      S_UC_WAIT: if (cache_data_data_ok)   w_next = S_IDLE;
      default:                             w_next = S_IDLE;
    endcase
  end

  // Outputs; everything is forced low while reset is asserted
  always_comb begin
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = '0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'd0;
    cache_data_addr  = '0;
    cache_data_wdata = '0;
    if (rst) begin
      case (r_state)
        S_IDLE:   cpu_data_addr_ok = cpu_data_req;
        S_LOOKUP: begin
          if (w_hit) begin
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = w_hit_data;
          end
        end
        S_WB_REQ: begin
          cache_data_req   = 1'b1;
          cache_data_wr    = 1'b1;
          cache_data_size  = 2'd2;
          cache_data_addr  = {w_vic_tag, w_index, 2'b00};
          cache_data_wdata = w_vic_data;
        end
        S_RF_REQ: begin
          cache_data_req   = 1'b1;
          cache_data_size  = 2'd2;
          cache_data_addr  = {r_addr[31:2], 2'b00};
        end
        S_UC_REQ: begin
          cache_data_req   = 1'b1;
          cache_data_wr    = r_wr;
          cache_data_size  = r_size;
          cache_data_addr  = r_addr;
          cache_data_wdata = r_wdata;
          if (cache_data_addr_ok && cache_data_data_ok) begin
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = cache_data_rdata;
          end
        end
        S_UC_WAIT: begin
          if (cache_data_data_ok) begin
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = cache_data_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Latch the accepted request; remember the victim chosen on a miss
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_victim <= '0;
    end else begin
      if (w_accept) begin
        r_wr    <= cpu_data_wr;
        r_size  <= cpu_data_size;
        r_addr  <= cpu_data_addr;
        r_wdata <= cpu_data_wdata;
      end
      if ((r_state == S_LOOKUP) && !w_hit) r_victim <= w_victim;
    end
  end

  // Valid/dirty bits and round-robin pointers; the pointer only moves when a valid line is evicted
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if ((r_state == S_LOOKUP) && w_hit && r_wr) r_dirty[w_index][w_hit_way] <= 1'b1;
      if ((r_state == S_LOOKUP) && !w_hit && !w_any_inv) r_rr[w_index] <= w_rr_next;
      if (w_refill_done) begin
        r_valid[w_index][r_victim] <= 1'b1;
        r_dirty[w_index][r_victim] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: write hits merge bytes, refills install the whole word
  always_ff @(posedge clk) begin
    if (rst) begin
      if ((r_state == S_LOOKUP) && w_hit && r_wr) r_data[w_hit_way][w_index] <= w_merged;
      if (w_refill_done) begin
        r_tag[r_victim][w_index]  <= w_tag;
        r_data[r_victim][w_index] <= cache_data_rdata;
      end
    end
  end

endmodule

// File: tb/tb_d_cache_nway_wb.sv
// tb_d_cache_nway_wb
// Directed scenarios followed by random traffic, checked against a reference model.
// The model is a word-level golden memory plus a per-set replacement model.
// The bus slave stalls and delays responses at random.

module tb_d_cache_nway_wb;

  localparam int WAYS = 2;
  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_data_req = 1'b0;
  logic        cpu_data_wr = 1'b0;
  logic [1:0]  cpu_data_size = 2'd0;
  logic [31:0] cpu_data_addr = '0;
  logic [31:0] cpu_data_wdata = '0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata = '0;
  logic        cache_data_addr_ok = 1'b0;
  logic        cache_data_data_ok = 1'b0;

  d_cache_nway_wb #(.WAYS(WAYS), .INDEX_WIDTH(6), .UNCACHED_EN(1'b1)) u_dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_data_req       (cpu_data_req),
    .cpu_data_wr        (cpu_data_wr),
    .cpu_data_size      (cpu_data_size),
    .cpu_data_addr      (cpu_data_addr),
    .cpu_data_wdata     (cpu_data_wdata),
    .cpu_data_rdata     (cpu_data_rdata),
    .cpu_data_addr_ok   (cpu_data_addr_ok),
    .cpu_data_data_ok   (cpu_data_data_ok),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dok_cyc = -100;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Memory behind the bus and the CPU-visible golden memory, both keyed by word address
  logic [31:0] mem  [logic [31:0]];
  logic [31:0] gold [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rd_gold(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_val(a);
  endfunction

  // A size-s access writes 2**s bytes starting at the byte offset
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    int nb;
    int first;
    r     = old;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    first = (size == 2'd2) ? 0 : int'(off);
    for (int b = first; b < first + nb && b < 4; b++) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  bus_t blog[$];
  int   stall_next = -1;
  int   dly_force  = -1;

  // Bus slave: random stall before addr_ok and random delay to data_ok; checks the request stays stable while stalled
  initial begin
    bit          pend;
    bit          seen;
    int          dly;
    int          stall;
    int          d;
    logic [31:0] prdata;
    bus_t        prev;
    bus_t        cur;
    pend = 0; seen = 0; dly = 0; stall = 0; prdata = '0;
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      cache_data_rdata   = $urandom;
      if (!rst) begin
        pend = 0;
        seen = 0;
      end else if (pend) begin
        if (dly == 0) begin
          cache_data_data_ok = 1'b1;
          cache_data_rdata   = prdata;
          dok_cyc            = cyc;
          pend               = 0;
        end else dly--;
      end else if (cache_data_req) begin
        cur.wr = cache_data_wr; cur.size = cache_data_size;
        cur.addr = cache_data_addr; cur.wdata = cache_data_wdata;
        if (seen) begin
          chk("bus_hold_wr",    32'(cur.wr),   32'(prev.wr));
          chk("bus_hold_size",  32'(cur.size), 32'(prev.size));
          chk("bus_hold_addr",  cur.addr,      prev.addr);
          chk("bus_hold_wdata", cur.wdata,     prev.wdata);
        end else begin
          seen  = 1;
          prev  = cur;
          stall = (stall_next >= 0) ? stall_next : $urandom_range(0, 2);
          stall_next = -1;
        end
        if (stall > 0) stall--;
        else begin
          cache_data_addr_ok = 1'b1;
          seen = 0;
          blog.push_back(cur);
          if (cur.wr) begin
            mem[{cur.addr[31:2], 2'b00}] = merge(rd_mem({cur.addr[31:2], 2'b00}), cur.wdata,
                                                 cur.size, cur.addr[1:0]);
            prdata = $urandom;
          end else prdata = rd_mem({cur.addr[31:2], 2'b00});
          d = (dly_force >= 0) ? dly_force : $urandom_range(0, 3);
          if (d == 0) begin
            cache_data_data_ok = 1'b1;
            cache_data_rdata   = prdata;
            dok_cyc            = cyc;
          end else begin
            pend = 1;
            dly  = d - 1;
          end
        end
      end else seen = 0;
    end
  end

  // Replacement model: per set, which lines are held and the round-robin pointer
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [23:0] m_tag   [SETS][WAYS];
  int          m_rr    [SETS];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = '0;
      end
    end
    gold = mem;
  endtask

  // One CPU access: predict, drive, wait for completion, then check data, latency and bus traffic
  task automatic access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit junk_all);
    logic [31:0] word;
    logic [31:0] exp_rd;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  s;
    logic [23:0] tag;
    bit          unc;
    bit          hit;
    bit          exp_wb;
    int          way;
    int          n;
    int          lat;
    int          base;
    word = {addr[31:2], 2'b00};
    unc  = (addr[31:29] == 3'b101);
    s    = addr[7:2];
    tag  = addr[31:8];
    hit  = 0; exp_wb = 0; way = 0; wb_addr = '0; wb_data = '0;
    exp_rd = rd_gold(word);
    if (!unc) begin
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_tag[s][w] == tag) begin hit = 1; way = w; end
      if (!hit) begin
        way = -1;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && way < 0) way = w;
        if (way < 0) begin
          way = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        if (m_valid[s][way] && m_dirty[s][way]) begin
          exp_wb  = 1;
          wb_addr = {m_tag[s][way], s, 2'b00};
          wb_data = rd_gold(wb_addr);
        end
        m_valid[s][way] = 1;
        m_dirty[s][way] = 0;
        m_tag[s][way]   = tag;
      end
      if (wr) m_dirty[s][way] = 1;
    end
    if (wr) gold[word] = merge(exp_rd, wdata, size, addr[1:0]);

    blog.delete();
    @(posedge clk); #1;
    cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = size;
    cpu_data_addr = addr; cpu_data_wdata = wdata;
    n = 0;
    forever begin
      @(negedge clk); #1;
      n++;
      if (cpu_data_addr_ok || n >= 20) break;
    end
    chk("accept_lat", 32'(n), 32'd1);
    if (!cpu_data_addr_ok) begin
      cpu_data_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cpu_data_req   = junk_all ? 1'b1 : 1'($urandom_range(0, 1));
    cpu_data_wr    = 1'($urandom_range(0, 1));
    cpu_data_addr  = $urandom;
    cpu_data_wdata = $urandom;
    lat = 0;
    forever begin
      @(negedge clk); #1;
      lat++;
      if (cpu_data_req) chk("busy_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
      if (cpu_data_data_ok || lat >= 300) break;
    end
    cpu_data_req = 1'b0;
    chk("data_ok", 32'(cpu_data_data_ok), 32'd1);
    if (!wr) chk(unc ? "uc_rdata" : "rdata", cpu_data_rdata, exp_rd);

    if (unc) begin
      chk("uc_dok_lat", 32'(cyc - dok_cyc), 32'd0);
      chk("uc_nbus", 32'(blog.size()), 32'd1);
      if (blog.size() >= 1) begin
        chk("uc_wr",   32'(blog[0].wr),   32'(wr));
        chk("uc_size", 32'(blog[0].size), 32'(size));
        chk("uc_addr", blog[0].addr,      addr);
        if (wr) chk("uc_wdata", blog[0].wdata, wdata);
      end
    end else if (hit) begin
      chk("hit_lat",   32'(lat),         32'd1);
      chk("hit_nobus", 32'(blog.size()), 32'd0);
    end else begin
      chk("miss_dok_lat", 32'(cyc - dok_cyc), 32'd1);
      chk("miss_nbus", 32'(blog.size()), exp_wb ? 32'd2 : 32'd1);
      base = 0;
      if (exp_wb && blog.size() >= 1) begin
        chk("wb_wr",    32'(blog[0].wr),   32'd1);
        chk("wb_size",  32'(blog[0].size), 32'd2);
        chk("wb_addr",  blog[0].addr,      wb_addr);
        chk("wb_wdata", blog[0].wdata,     wb_data);
        base = 1;
      end
      if (blog.size() > base) begin
        chk("rf_wr",   32'(blog[base].wr),   32'd0);
        chk("rf_size", 32'(blog[base].size), 32'd2);
        chk("rf_addr", blog[base].addr,      word);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_aok"},   32'(cpu_data_addr_ok), 32'd0);
    chk({tag, "_dok"},   32'(cpu_data_data_ok), 32'd0);
    chk({tag, "_rdata"}, cpu_data_rdata,        32'd0);
    chk({tag, "_breq"},  32'(cache_data_req),   32'd0);
    chk({tag, "_bwr"},   32'(cache_data_wr),    32'd0);
    chk({tag, "_bsize"}, 32'(cache_data_size),  32'd0);
    chk({tag, "_baddr"}, cache_data_addr,       32'd0);
    chk({tag, "_bwdat"}, cache_data_wdata,      32'd0);
  endtask

  initial begin
    int          n;
    int          r;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] a;
    logic [5:0]  sel_set;

    // reset with a pending CPU request: nothing may respond
    rst = 1'b0;
    cpu_data_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_outputs_zero("rst");
    @(posedge clk); #1;
    cpu_data_req = 1'b0;
    rst = 1'b1;
    mem[32'h40] = 32'h1122_3344;
    model_reset();

    // read miss then reread hit
    access(1'b0, 2'd2, 32'h0000_0040, '0, 1'b0);
    chk("t1_rdata", cpu_data_rdata, 32'h1122_3344);
    if (blog.size() >= 1) chk("t1_rf_addr", blog[0].addr, 32'h0000_0040);
    access(1'b0, 2'd2, 32'h0000_0040, '0, 1'b0);

    // byte write hit
    access(1'b1, 2'd0, 32'h0000_0041, 32'h0000_AB00, 1'b0);
    access(1'b0, 2'd2, 32'h0000_0040, '0, 1'b0);
    chk("t2_rdata", cpu_data_rdata, 32'h1122_AB44);

    // set 16 with three tags: the dirty way 0 is written back, then the pointer selects way 1
    access(1'b0, 2'd2, 32'h0000_0140, '0, 1'b0);
    access(1'b0, 2'd2, 32'h0000_0240, '0, 1'b0);
    if (blog.size() >= 2) begin
      chk("t3_wb_addr",  blog[0].addr,     32'h0000_0040);
      chk("t3_wb_data",  blog[0].wdata,    32'h1122_AB44);
      chk("t3_wb_wr",    32'(blog[0].wr),  32'd1);
      chk("t3_rf_addr",  blog[1].addr,     32'h0000_0240);
    end
    access(1'b0, 2'd2, 32'h0000_0340, '0, 1'b0);
    chk("t3_rr_nowb", 32'(blog.size()), 32'd1);
    access(1'b0, 2'd2, 32'h0000_0240, '0, 1'b0);

    // uncached reads both go to the bus
    access(1'b0, 2'd2, 32'hBFC0_0000, '0, 1'b0);
    access(1'b0, 2'd2, 32'hBFC0_0000, '0, 1'b0);
    if (blog.size() >= 1) chk("t4_uc_addr", blog[0].addr, 32'hBFC0_0000);

    // write-back stalled for 5 cycles while the CPU keeps requesting
    access(1'b1, 2'd2, 32'h0000_0240, 32'hDEAD_BEEF, 1'b0);
    stall_next = 5;
    access(1'b0, 2'd2, 32'h0000_0440, '0, 1'b1);
    if (blog.size() >= 1) begin
      chk("t5_wb_addr", blog[0].addr,  32'h0000_0240);
      chk("t5_wb_data", blog[0].wdata, 32'hDEAD_BEEF);
    end

    // reset while waiting on refill data
    dly_force = 8;
    blog.delete();
    @(posedge clk); #1;
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'd2; cpu_data_addr = 32'h0000_0540;
    @(negedge clk); #1;
    chk("t6_accept", 32'(cpu_data_addr_ok), 32'd1);
    @(posedge clk); #1;
    cpu_data_req = 1'b0;
    n = 0;
    while (blog.size() == 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t6_rf_seen", 32'(blog.size()), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_data_req = 1'b1;
    @(negedge clk); #1;
    check_outputs_zero("t6");
    @(posedge clk); #1;
    cpu_data_req = 1'b0;
    dly_force = -1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    access(1'b0, 2'd2, 32'h0000_0540, '0, 1'b0);
    chk("t6_remiss", 32'(blog.size()), 32'd1);

    // random traffic over a few sets, several tags and some kseg1 accesses
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 2));
      case (sz)
        2'd0:    off = 2'($urandom_range(0, 3));
        2'd1:    off = $urandom_range(0, 1) ? 2'd2 : 2'd0;
        default: off = 2'd0;
      endcase
      if (r == 0) a = 32'hBFC0_0000 + 32'($urandom_range(0, 7) * 4);
      else begin
        case ($urandom_range(0, 3))
          0:       sel_set = 6'd16;
          1:       sel_set = 6'd17;
          2:       sel_set = 6'd0;
          default: sel_set = 6'd63;
        endcase
        a = {24'($urandom_range(0, 5)), sel_set, 2'b00};
      end
      a = {a[31:2], off};
      access(1'($urandom_range(0, 1)), sz, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
